// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: 25 MHz pixel enable from a 50 MHz clock,
// horizontal/vertical counters and registered sync, visible-area and frame-start outputs.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       pix_tick_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       video_on_o,
  output logic [9:0] pixel_x_o,
  output logic [9:0] pixel_y_o,
  output logic       frame_start_o
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       frame_wrap;
  logic       hsync_act;
  logic       vsync_act;

  // Next-state counters; every output register below decodes these so that
  // sync, video_on and coordinates always describe the same pixel.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    h_next     = pixel_x_o;
    v_next     = pixel_y_o;
    frame_wrap = 1'b0;
    if (pix_tick_o) begin
      if (pixel_x_o == H_LAST) begin
        h_next = '0;
        if (pixel_y_o == V_LAST) begin
          v_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          v_next = pixel_y_o + 10'd1;
        end
      end else begin
        h_next = pixel_x_o + 10'd1;
      end
    end
  end

  assign hsync_act = (h_next >= HS_START) && (h_next < HS_END);
  assign vsync_act = (v_next >= VS_START) && (v_next < VS_END);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_tick_o    <= 1'b0;
      pixel_x_o     <= '0;
      pixel_y_o     <= '0;
      video_on_o    <= 1'b1;
      hsync_o       <= ~SYNC_POL;
      vsync_o       <= ~SYNC_POL;
      frame_start_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pix_tick_o    <= ~pix_tick_o;
      pixel_x_o     <= h_next;
      pixel_y_o     <= v_next;
      video_on_o    <= (h_next < H_VIS) && (v_next < V_VIS);
      hsync_o       <= hsync_act ? SYNC_POL : ~SYNC_POL;
      vsync_o       <= vsync_act ? SYNC_POL : ~SYNC_POL;
      frame_start_o <= frame_wrap;
    end
  end

endmodule
